// File: rtl/vram_arb_pkg.sv
// Shared types for the shadow-VRAM read arbiter.
//   owner_e : which requester an in-flight read belongs to
//   WAIT_W  : width of the starvation counter (holds MAX_WAIT up to 15)
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_VGC   = 2'd2
    } owner_e;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/vram_arb_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency.
//   clk_logic : rising-edge clock
//   clr       : synchronous clear, empties every stage to OWN_NONE
//   tag_in    : owner of the read issued to the RAM this cycle
//   tag_out   : owner of the read whose data is on ram_data_i this cycle
module vram_arb_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk_logic,
    input  logic   clr,
    input  owner_e tag_in,
    output owner_e tag_out
);

    owner_e [DEPTH-1:0] stage;

    always_ff @(posedge clk_logic) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// Two-requester arbiter for one shadow-VRAM read port (video scanner vs VGC).
//   clk_logic, system_reset_n   : clock, synchronous active-low reset
//   vgc_active_i                : 1 = VGC high priority, 0 = video high priority
//   video_req_i/addr_i/gnt_o    : video request handshake (gnt combinational)
//   video_valid_o/data_o        : video return pulse and held data
//   vgc_req_i/addr_i/gnt_o      : VGC request handshake (gnt combinational)
//   vgc_valid_o/data_o          : VGC return pulse and held data
//   ram_rd_o/ram_addr_o         : registered RAM read command
//   ram_data_i                  : RAM read data, RAM_LATENCY cycles after ram_rd_o
module vram_read_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_WAIT    = 3
) (
    input  logic                  clk_logic,
    input  logic                  system_reset_n,
    input  logic                  vgc_active_i,
    input  logic                  video_req_i,
    input  logic [ADDR_WIDTH-1:0] video_addr_i,
    output logic                  video_gnt_o,
    output logic                  video_valid_o,
    output logic [DATA_WIDTH-1:0] video_data_o,
    input  logic                  vgc_req_i,
    input  logic [ADDR_WIDTH-1:0] vgc_addr_i,
    output logic                  vgc_gnt_o,
    output logic                  vgc_valid_o,
    output logic [DATA_WIDTH-1:0] vgc_data_o,
    output logic                  ram_rd_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    logic [WAIT_W-1:0] wait_cnt, wait_eff;
    logic              mode_q, mode_chg;
    logic              hi_req, lo_req, hi_win, lo_win;
    owner_e            grant_own, issue_tag, ret_tag;

    // A priority flip restarts the starvation count in the same cycle,
    // so the newly-high side is not immediately overruled.
    assign mode_chg = vgc_active_i != mode_q;
    assign wait_eff = mode_chg ? '0 : wait_cnt;

    assign hi_req = vgc_active_i ? vgc_req_i   : video_req_i;
    assign lo_req = vgc_active_i ? video_req_i : vgc_req_i;

    // Low side wins when alone, or when it has lost MAX_WAIT contended cycles.
    assign lo_win = lo_req & (~hi_req | (wait_eff == WAIT_W'(MAX_WAIT)));
    assign hi_win = hi_req & ~lo_win;

    assign video_gnt_o = system_reset_n & (vgc_active_i ? lo_win : hi_win);
    assign vgc_gnt_o   = system_reset_n & (vgc_active_i ? hi_win : lo_win);

    assign grant_own = vgc_gnt_o   ? OWN_VGC   :
                       video_gnt_o ? OWN_VIDEO : OWN_NONE;

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            wait_cnt   <= '0;
            mode_q     <= 1'b0;
            ram_rd_o   <= 1'b0;
            ram_addr_o <= '0;
            issue_tag  <= OWN_NONE;
        end else begin
            mode_q <= vgc_active_i;
            // Counts only contended cycles the low side lost; anything else clears.
            if (hi_win && lo_req)
                wait_cnt <= (wait_eff < WAIT_W'(MAX_WAIT)) ? wait_eff + WAIT_W'(1) : wait_eff;
            else
                wait_cnt <= '0;
            ram_rd_o  <= grant_own != OWN_NONE;
            issue_tag <= grant_own;
            if (grant_own != OWN_NONE)
                ram_addr_o <= vgc_gnt_o ? vgc_addr_i : video_addr_i;
        end
    end

    vram_arb_tag_pipe #(
        .DEPTH (RAM_LATENCY)
    ) u_tag_pipe (
        .clk_logic (clk_logic),
        .clr       (~system_reset_n),
        .tag_in    (issue_tag),
        .tag_out   (ret_tag)
    );

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            video_valid_o <= 1'b0;
            video_data_o  <= '0;
            vgc_valid_o   <= 1'b0;
            vgc_data_o    <= '0;
        end else begin
            video_valid_o <= ret_tag == OWN_VIDEO;
            vgc_valid_o   <= ret_tag == OWN_VGC;
            if (ret_tag == OWN_VIDEO) video_data_o <= ram_data_i;
            if (ret_tag == OWN_VGC)   vgc_data_o   <= ram_data_i;
        end
    end

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Bench for vram_read_arbiter: one instance at RAM_LATENCY=1 and one at 4,
// driven by the same requests and checked against a cycle-level model.
module tb_vram_read_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int NS = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, vgc_active = 1'b0;
    logic          video_req = 1'b0, vgc_req = 1'b0;
    logic [AW-1:0] video_addr = '0, vgc_addr = '0;

    logic [1:0]         vgnt, ggnt, vval, gval, rrd;
    logic [1:0][AW-1:0] raddr;
    logic [1:0][DW-1:0] vdat, gdat, rdat;

    vram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1), .MAX_WAIT(MW)) u_dut_l1 (
        .clk_logic(clk), .system_reset_n(rst_n), .vgc_active_i(vgc_active),
        .video_req_i(video_req), .video_addr_i(video_addr), .video_gnt_o(vgnt[0]),
        .video_valid_o(vval[0]), .video_data_o(vdat[0]),
        .vgc_req_i(vgc_req), .vgc_addr_i(vgc_addr), .vgc_gnt_o(ggnt[0]),
        .vgc_valid_o(gval[0]), .vgc_data_o(gdat[0]),
        .ram_rd_o(rrd[0]), .ram_addr_o(raddr[0]), .ram_data_i(rdat[0]));

    vram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(4), .MAX_WAIT(MW)) u_dut_l4 (
        .clk_logic(clk), .system_reset_n(rst_n), .vgc_active_i(vgc_active),
        .video_req_i(video_req), .video_addr_i(video_addr), .video_gnt_o(vgnt[1]),
        .video_valid_o(vval[1]), .video_data_o(vdat[1]),
        .vgc_req_i(vgc_req), .vgc_addr_i(vgc_addr), .vgc_gnt_o(ggnt[1]),
        .vgc_valid_o(gval[1]), .vgc_data_o(gdat[1]),
        .ram_rd_o(rrd[1]), .ram_addr_o(raddr[1]), .ram_data_i(rdat[1]));

    // RAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
        if (a == 12'h123) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
    endfunction

    // RAM read paths: address sampled each edge, data after 1 / 4 cycles.
    logic [AW-1:0] ap1;
    logic [AW-1:0] ap4 [4];
    always @(posedge clk) begin
        ap1    <= raddr[0];
        ap4[0] <= raddr[1];
        for (int i = 1; i < 4; i++) ap4[i] <= ap4[i-1];
    end
    assign rdat[0] = ram_fn(ap1);
    assign rdat[1] = ram_fn(ap4[3]);

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    int checks = 0, errors = 0;
    int cyc = 0;
    bit regs_known = 1'b0;
    bit rec = 1'b0;
    string gseq;

    // Model state.
    int            m_wait = 0;
    logic          m_prev = 1'b0;
    logic [1:0]    sched   [2][NS];  // 0 none, 1 video, 2 vgc: return due that cycle
    logic [AW-1:0] sched_a [2][NS];
    logic          e_rd   [2];
    logic [AW-1:0] e_addr [2];
    logic          e_vv [2], e_gv [2];
    logic [DW-1:0] e_vd [2], e_gd [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rn, input logic md, input logic vr, input logic [AW-1:0] va,
                        input logic gr, input logic [AW-1:0] ga);
        int   eff;
        logic hi, lo, hw, lw, egv, egg;
        rst_n = rn; vgc_active = md; video_req = vr; video_addr = va; vgc_req = gr; vgc_addr = ga;
        @(negedge clk);
        // Returns scheduled for this cycle.
        for (int k = 0; k < 2; k++) begin
            e_vv[k] = sched[k][cyc] == 2'd1;
            e_gv[k] = sched[k][cyc] == 2'd2;
            if (e_vv[k]) e_vd[k] = ram_fn(sched_a[k][cyc]);
            if (e_gv[k]) e_gd[k] = ram_fn(sched_a[k][cyc]);
        end
        // Arbitration rules.
        hi  = md ? gr : vr;
        lo  = md ? vr : gr;
        eff = (md != m_prev) ? 0 : m_wait;
        lw  = rn && lo && (!hi || eff == MW);
        hw  = rn && hi && !lw;
        egv = md ? lw : hw;
        egg = md ? hw : lw;
        if (rec) gseq = {gseq, egv ? "V" : egg ? "G" : "-"};
        for (int k = 0; k < 2; k++) begin
            check($sformatf("video_gnt[%0d]@%0d", k, cyc), 64'(vgnt[k]), 64'(egv));
            check($sformatf("vgc_gnt[%0d]@%0d", k, cyc), 64'(ggnt[k]), 64'(egg));
            if (regs_known) begin
                check($sformatf("ram_rd[%0d]@%0d", k, cyc), 64'(rrd[k]), 64'(e_rd[k]));
                check($sformatf("ram_addr[%0d]@%0d", k, cyc), 64'(raddr[k]), 64'(e_addr[k]));
                check($sformatf("video_valid[%0d]@%0d", k, cyc), 64'(vval[k]), 64'(e_vv[k]));
                check($sformatf("vgc_valid[%0d]@%0d", k, cyc), 64'(gval[k]), 64'(e_gv[k]));
                check($sformatf("video_data[%0d]@%0d", k, cyc), 64'(vdat[k]), 64'(e_vd[k]));
                check($sformatf("vgc_data[%0d]@%0d", k, cyc), 64'(gdat[k]), 64'(e_gd[k]));
            end
        end
        @(posedge clk);
        // Model update for this edge.
        if (!rn) begin
            m_wait = 0; m_prev = 1'b0;
            for (int k = 0; k < 2; k++) begin
                e_rd[k] = 1'b0; e_addr[k] = '0;
                e_vd[k] = '0;   e_gd[k]   = '0;
                for (int c = cyc + 1; c < cyc + 8 && c < NS; c++) sched[k][c] = 2'd0;
            end
            regs_known = 1'b1;
        end else begin
            m_wait = (hw && lo) ? ((eff < MW) ? eff + 1 : eff) : 0;
            m_prev = md;
            for (int k = 0; k < 2; k++) begin
                e_rd[k] = egv || egg;
                if (egv || egg) begin
                    e_addr[k] = egg ? ga : va;
                    if (cyc + 2 + lat(k) < NS) begin
                        sched[k][cyc + 2 + lat(k)]   = egg ? 2'd2 : 2'd1;
                        sched_a[k][cyc + 2 + lat(k)] = egg ? ga : va;
                    end
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, vgc_active, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NS; c++) begin sched[k][c] = 2'd0; sched_a[k][c] = '0; end
        #1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(2);

        // Reset in the middle of a video burst: earlier grants never return.
        step(1'b1, 1'b0, 1'b1, 12'h010, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 12'h010, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 12'h010, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 12'h010, 1'b0, '0);
        idle(7);

        // Single requester latency.
        step(1'b1, 1'b0, 1'b1, 12'h123, 1'b0, '0);
        idle(7);

        // Contention with the starvation guard.
        gseq = ""; rec = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 12'(12'h200 + i), 1'b1, 12'(12'h300 + i));
        rec = 1'b0;
        checks++;
        assert (gseq == "VVVGVVVGVVVG") else begin
            errors++; $error("FAIL grant_seq observed=%s expected=VVVGVVVGVVVG", gseq);
        end
        idle(7);

        // Priority flip after two grants.
        gseq = ""; rec = 1'b1;
        for (int i = 0; i < 10; i++)
            step(1'b1, (i >= 2) ? 1'b1 : 1'b0, 1'b1, 12'(12'h400 + i), 1'b1, 12'(12'h500 + i));
        rec = 1'b0;
        checks++;
        assert (gseq == "VVGGGVGGGV") else begin
            errors++; $error("FAIL mode_switch_seq observed=%s expected=VVGGGVGGGV", gseq);
        end
        idle(7);

        // Alternating single-cycle requests.
        step(1'b1, 1'b0, 1'b1, 12'h001, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 12'h002);
        step(1'b1, 1'b0, 1'b1, 12'h003, 1'b0, '0);
        idle(10);

        // Random traffic, priority flips and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic md;
            md = vgc_active;
            if ($urandom_range(0, 19) == 0) md = ~md;
            step(($urandom_range(0, 79) != 0), md,
                 ($urandom_range(0, 9) < 7), 12'($urandom),
                 ($urandom_range(0, 9) < 7), 12'($urandom));
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Both returns in one cycle is never legal.
    always @(negedge clk) begin
        if (regs_known) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                assert ((vval[k] & gval[k]) === 1'b0) else begin
                    errors++; $error("FAIL dual_valid[%0d] observed=1 expected=0", k);
                end
            end
        end
    end

endmodule

// File: doc/vram_read_arbiter.md
Name: vram_read_arbiter

Overview:
Shares one read port of a shadow-VRAM sdpram32 bank between two requesters: the Apple II video scanner and the VGC fetch engine. It uses req/gnt handshakes, mode-dependent fixed priority and a starvation guard for the low-priority side. It tracks in-flight reads through a tag pipeline matched to the RAM read latency and returns registered data to the owning requester. It sits between the video/VGC fetch logic and the hires aux bank read port in the apple memory subsystem.

Parameters:
ADDR_WIDTH, 12, word address width of the RAM read port
DATA_WIDTH, 32, RAM read data width
RAM_LATENCY, 1, cycles from registered ram_rd_o to valid ram_data_i; legal range 1..4
MAX_WAIT, 3, consecutive lost contended cycles before the low-priority requester is forced to win; legal range 1..15

Ports:
clk_logic  in  1  system logic clock; all state changes on its rising edge
system_reset_n  in  1  reset, synchronous, active-low
vgc_active_i  in  1  1 = VGC is high priority, 0 = video is high priority
video_req_i  in  1  video read request; held high with stable address until granted
video_addr_i  in  ADDR_WIDTH  video read word address
video_gnt_o  in/out: out  1  video request accepted this cycle (combinational)
video_valid_o  out  1  one-cycle pulse: video_data_o holds a new word
video_data_o  out  DATA_WIDTH  last word returned to video; held between pulses
vgc_req_i  in  1  VGC read request; same rules as video_req_i
vgc_addr_i  in  ADDR_WIDTH  VGC read word address
vgc_gnt_o  out  1  VGC request accepted this cycle (combinational)
vgc_valid_o  out  1  one-cycle pulse: vgc_data_o holds a new word
vgc_data_o  out  DATA_WIDTH  last word returned to VGC; held between pulses
ram_rd_o  out  1  registered read enable to the RAM
ram_addr_o  out  ADDR_WIDTH  registered read address to the RAM
ram_data_i  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (system_reset_n = 0 at an edge): every registered output goes to 0 (ram_rd_o, ram_addr_o, *_valid_o, *_data_o). The starvation counter and all tag stages clear. While reset is low, both gnt outputs are forced to 0.
- At most one grant per cycle; the arbiter accepts one read every cycle (no bubbles).
- High-priority side: VGC if vgc_active_i = 1, else video.
- Single request: it is granted the same cycle.
- Both requesting:
  - wait_cnt < MAX_WAIT: high side wins and wait_cnt increments, saturating at MAX_WAIT.
  - wait_cnt == MAX_WAIT: low side wins and wait_cnt clears to 0.
- wait_cnt clears to 0 when the low side is not requesting, when the low side is granted, or when vgc_active_i differs from its value registered the previous cycle. The clear caused by a vgc_active_i change takes effect in the same cycle as the change.
- Issue: in grant cycle N, ram_rd_o = 1 at N+1 and ram_addr_o = the winner's address. With no grant, ram_rd_o = 0 and ram_addr_o holds its last value.
- Tag pipeline: owner tag (NONE/VIDEO/VGC) enters at N+1 and is delayed RAM_LATENCY cycles. When it emerges, the owner's data register captures ram_data_i. The owner's valid pulses at N+2+RAM_LATENCY (cycle N+3 for the default). The other requester's data is untouched.
- Returns stay in grant order. Both valid outputs are never high in the same cycle.
- A request dropped before grant is ignored. Address changes while req is high and ungranted are legal; the address sampled in the grant cycle is used.
- Reset mid-operation: in-flight reads are discarded; no valid pulse follows reset release for reads granted before reset.
- Both requesting every cycle with vgc_active_i steady: the high side gets MAX_WAIT grants, then the low side gets 1, repeating (period MAX_WAIT+1).

Decomposition:
- Package vram_arb_pkg:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_VIDEO, OWN_VGC}
  - localparam WAIT_W = 4 (counter width)
- Sub-module vram_arb_tag_pipe: parameterised RAM_LATENCY-deep shift register of owner_e with synchronous clear.
- Arbitration, counter and output registers stay in the top module.

Test Plan:
1. Reset mid-burst:
   - Stimulus: default params, vgc_active_i = 0, video_req_i = 1 at addr 0x010; at cycle 2 assert reset for 1 cycle.
   - Required: all outputs are 0 after reset; no video_valid_o pulse from the pre-reset grant; the next grant is issued normally.
2. Single requester latency:
   - Stimulus: video_req_i = 1 at addr 0x123 in cycle 0 only; RAM model returns 0xDEADBEEF for addr 0x123.
   - Required: video_gnt_o = 1 in cycle 0; ram_rd_o = 1 with ram_addr_o = 0x123 in cycle 1; video_valid_o pulses in cycle 3 with video_data_o = 0xDEADBEEF; vgc outputs stay 0.
3. Contention and starvation guard:
   - Stimulus: vgc_active_i = 0, MAX_WAIT = 3, both requesting continuously for 12 cycles.
   - Required: grant sequence V,V,V,G,V,V,V,G,V,V,V,G; returned data routed to the matching requester 3 cycles after each grant.
4. Mode switch:
   - Stimulus: same stimulus as scenario 3, but vgc_active_i toggles to 1 after the 2nd grant.
   - Required: wait_cnt clears; the following grants are G,G,G,V,...; no return is misrouted across the switch.
5. Latency sweep:
   - Stimulus: RAM_LATENCY = 4; alternate single-cycle requests video 0x001, vgc 0x002, video 0x003.
   - Required: valids at cycles 6, 7, 8 with the correct owners and data; data registers hold their values between pulses.
